// File: rtl/video_pattern_gen.sv
// Video timing generator with runtime-selectable test pattern, moving box and frame counter.
// Every output is registered from next-state coordinates so timing strobes and colour stay aligned.
module video_pattern_gen #(
   parameter int HRES       = 640,
   parameter int VRES       = 480,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit H_POL      = 1'b0,
   parameter bit V_POL      = 1'b0,
   parameter int COORDSPC   = 16,
   parameter int COLSPC     = 10,
   parameter int CHECK_LOG2 = 5,
   parameter int BOX        = 32
) (
   input  logic                       video_clk_pix,
   input  logic                       rst_pix,
   input  logic [1:0]                 pattern,
   output logic                       video_enable,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       line_start,
   output logic                       frame_start,
   output logic signed [COORDSPC-1:0] sx,
   output logic signed [COORDSPC-1:0] sy,
   output logic [COLSPC-1:0]          red,
   output logic [COLSPC-1:0]          green,
   output logic [COLSPC-1:0]          blue,
   output logic [15:0]                frame_count
);

   localparam logic signed [COORDSPC-1:0] ONE    = COORDSPC'(1);
   localparam logic signed [COORDSPC-1:0] ZERO   = COORDSPC'(0);
   localparam logic signed [COORDSPC-1:0] H_STA  = COORDSPC'(-(H_FP + H_SYNC + H_BP));
   localparam logic signed [COORDSPC-1:0] V_STA  = COORDSPC'(-(V_FP + V_SYNC + V_BP));
   localparam logic signed [COORDSPC-1:0] H_END  = COORDSPC'(HRES - 1);
   localparam logic signed [COORDSPC-1:0] V_END  = COORDSPC'(VRES - 1);
   localparam logic signed [COORDSPC-1:0] HS_BEG = COORDSPC'(-(H_SYNC + H_BP));
   localparam logic signed [COORDSPC-1:0] HS_END = COORDSPC'(-H_BP - 1);
   localparam logic signed [COORDSPC-1:0] VS_BEG = COORDSPC'(-(V_SYNC + V_BP));
   localparam logic signed [COORDSPC-1:0] VS_END = COORDSPC'(-V_BP - 1);
   localparam logic signed [COORDSPC-1:0] X_MAX  = COORDSPC'(HRES - BOX);
   localparam logic signed [COORDSPC-1:0] Y_MAX  = COORDSPC'(VRES - BOX);
   localparam logic signed [COORDSPC-1:0] BOX_W  = COORDSPC'(BOX);
   localparam logic signed [COORDSPC-1:0] BAR_W  = COORDSPC'(HRES / 8);

   logic signed [COORDSPC-1:0] sx_n, sy_n;
   logic signed [COORDSPC-1:0] box_x, box_y, box_x_n, box_y_n;
   logic                       dx_neg, dy_neg, dx_neg_n, dy_neg_n;
   logic [1:0]                 mode_q;
   logic                       en_n, in_box;
   logic [2:0]                 bar;
   logic [COLSPC-1:0]          red_n, green_n, blue_n;

   // raster position for the next cycle
   always_comb begin
      sx_n = sx + ONE;
      sy_n = sy;
      if (sx == H_END) begin
         sx_n = H_STA;
         sy_n = (sy == V_END) ? V_STA : sy + ONE;
      end
   end

   // box bounces: at an edge the direction flips and the step reverses in the same frame
   always_comb begin
      box_x_n  = box_x;
      box_y_n  = box_y;
      dx_neg_n = dx_neg;
      dy_neg_n = dy_neg;
      if (!dx_neg) begin
         if (box_x >= X_MAX) begin dx_neg_n = 1'b1; box_x_n = box_x - ONE; end
         else                       box_x_n = box_x + ONE;
      end else begin
         if (box_x <= ZERO) begin dx_neg_n = 1'b0; box_x_n = box_x + ONE; end
         else                      box_x_n = box_x - ONE;
      end
      if (!dy_neg) begin
         if (box_y >= Y_MAX) begin dy_neg_n = 1'b1; box_y_n = box_y - ONE; end
         else                       box_y_n = box_y + ONE;
      end else begin
         if (box_y <= ZERO) begin dy_neg_n = 1'b0; box_y_n = box_y + ONE; end
         else                      box_y_n = box_y - ONE;
      end
   end

   // pixel colour for the next coordinate
   always_comb begin
      en_n    = !sx_n[COORDSPC-1] && !sy_n[COORDSPC-1];
      bar     = 3'($unsigned(sx_n) / $unsigned(BAR_W));
      in_box  = (sx_n >= box_x) && (sx_n < box_x + BOX_W) &&
                (sy_n >= box_y) && (sy_n < box_y + BOX_W);
      red_n   = '0;
      green_n = '0;
      blue_n  = '0;
      if (en_n) begin
         case (mode_q)
            2'd0: begin
               red_n   = COLSPC'(sx_n);
               green_n = COLSPC'(sx_n);
               blue_n  = COLSPC'(sx_n);
            end
            2'd1: begin
               red_n   = {COLSPC{~bar[1]}};
               green_n = {COLSPC{~bar[2]}};
               blue_n  = {COLSPC{~bar[0]}};
            end
            2'd2: begin
               red_n   = {COLSPC{sx_n[CHECK_LOG2] ^ sy_n[CHECK_LOG2]}};
               green_n = {COLSPC{sx_n[CHECK_LOG2] ^ sy_n[CHECK_LOG2]}};
               blue_n  = {COLSPC{sx_n[CHECK_LOG2] ^ sy_n[CHECK_LOG2]}};
            end
            default: begin
               red_n   = {COLSPC{in_box}};
               green_n = {COLSPC{in_box}};
               blue_n  = {COLSPC{in_box}};
            end
         endcase
      end
   end

   always_ff @(posedge video_clk_pix) begin
      if (rst_pix) begin
         sx           <= H_STA;
         sy           <= V_STA;
         line_start   <= 1'b1;
         frame_start  <= 1'b1;
         hsync        <= ~H_POL;
         vsync        <= ~V_POL;
         video_enable <= 1'b0;
         red          <= '0;
         green        <= '0;
         blue         <= '0;
         frame_count  <= '0;
         mode_q       <= 2'd0;
         box_x        <= ZERO;
         box_y        <= ZERO;
         dx_neg       <= 1'b0;
         dy_neg       <= 1'b0;
      end else begin
         sx           <= sx_n;
         sy           <= sy_n;
         line_start   <= (sx_n == H_STA);
         frame_start  <= (sx_n == H_STA) && (sy_n == V_STA);
         hsync        <= (sx_n >= HS_BEG && sx_n <= HS_END) ? H_POL : ~H_POL;
         vsync        <= (sy_n >= VS_BEG && sy_n <= VS_END) ? V_POL : ~V_POL;
         video_enable <= en_n;
         red          <= red_n;
         green        <= green_n;
         blue         <= blue_n;
         if (frame_start) begin
            frame_count <= frame_count + 16'd1;
            mode_q      <= pattern;
            box_x       <= box_x_n;
            box_y       <= box_y_n;
            dx_neg      <= dx_neg_n;
            dy_neg      <= dy_neg_n;
         end
      end
   end

endmodule
